// File: rtl/w0rm_peripheral_memory_dualport_if.sv
// Request/response bundle for one W0RM peripheral memory port.
// The master drives requests; the slave answers with registered responses.
interface w0rm_peripheral_memory_dualport_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = 32
) ();
  logic                    req_valid;
  logic                    read;
  logic                    write;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] be;
  logic [USER_WIDTH-1:0]   req_user;
  logic                    rsp_valid;
  logic                    err;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [USER_WIDTH-1:0]   rsp_user;

  modport master (
    output req_valid, read, write, addr, wdata, be, req_user,
    input  rsp_valid, err, rdata, rsp_user
  );

  modport slave (
    input  req_valid, read, write, addr, wdata, be, req_user,
    output rsp_valid, err, rdata, rsp_user
  );
endinterface

// File: rtl/w0rm_peripheral_memory_dualport.sv
// Dual-port word RAM on the W0RM peripheral bus: byte enables, base-address decode
// with error response, read-first ordering and 1- or 2-cycle registered read latency.
module w0rm_peripheral_memory_dualport #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    MEM_DEPTH    = 512,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 32'h4000_0000,
  parameter string                 INIT_FILE    = "",
  parameter int                    USER_WIDTH   = 32,
  parameter int                    READ_LATENCY = 1
) (
  input logic                              mem_clk,
  input logic                              cpu_reset,
  w0rm_peripheral_memory_dualport_if.slave port_a,
  w0rm_peripheral_memory_dualport_if.slave port_b
);

  localparam int NB       = DATA_WIDTH / 8;
  localparam int BYTE_LSB = (NB > 1) ? $clog2(NB) : 0;
  localparam int IDX_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] WINDOW = (ADDR_WIDTH + 1)'(MEM_DEPTH * NB);

  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("READ_LATENCY must be 1 or 2");
  end

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic                  req_valid [2];
  logic                  rd        [2];
  logic                  wr        [2];
  logic [ADDR_WIDTH-1:0] addr      [2];
  logic [DATA_WIDTH-1:0] wdata     [2];
  logic [NB-1:0]         be        [2];
  logic [USER_WIDTH-1:0] req_user  [2];
  logic                  rsp_valid [2];
  logic                  rsp_err   [2];
  logic [DATA_WIDTH-1:0] rsp_data  [2];
  logic [USER_WIDTH-1:0] rsp_user  [2];
  logic [IDX_W-1:0]      idx       [2];
  logic                  wr_en     [2];

  assign req_valid[0] = port_a.req_valid;
  assign req_valid[1] = port_b.req_valid;
  assign rd[0]        = port_a.read;
  assign rd[1]        = port_b.read;
  assign wr[0]        = port_a.write;
  assign wr[1]        = port_b.write;
  assign addr[0]      = port_a.addr;
  assign addr[1]      = port_b.addr;
  assign wdata[0]     = port_a.wdata;
  assign wdata[1]     = port_b.wdata;
  assign be[0]        = port_a.be;
  assign be[1]        = port_b.be;
  assign req_user[0]  = port_a.req_user;
  assign req_user[1]  = port_b.req_user;

  assign port_a.rsp_valid = rsp_valid[0];
  assign port_b.rsp_valid = rsp_valid[1];
  assign port_a.err       = rsp_err[0];
  assign port_b.err       = rsp_err[1];
  assign port_a.rdata     = rsp_data[0];
  assign port_b.rdata     = rsp_data[1];
  assign port_a.rsp_user  = rsp_user[0];
  assign port_b.rsp_user  = rsp_user[1];

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    logic [ADDR_WIDTH-1:0] offset;
    logic                  hit;
    logic                  accept;
    logic                  s1_valid_reg;
    logic                  s1_err_reg;
    logic [DATA_WIDTH-1:0] s1_data_reg;
    logic [USER_WIDTH-1:0] s1_user_reg;

    // The explicit lower-bound test catches addresses whose offset wraps around.
    assign offset    = addr[gi] - BASE_ADDR;
    assign hit       = (addr[gi] >= BASE_ADDR) && ({1'b0, offset} < WINDOW);
    assign idx[gi]   = IDX_W'(offset >> BYTE_LSB);
    assign accept    = cpu_reset && req_valid[gi] && (rd[gi] || wr[gi]);
    assign wr_en[gi] = accept && wr[gi] && hit;

    always_ff @(posedge mem_clk) begin
      if (!cpu_reset) begin
        s1_valid_reg <= 1'b0;
        s1_err_reg   <= 1'b0;
        s1_data_reg  <= '0;
        s1_user_reg  <= '0;
      end else begin
        s1_valid_reg <= accept;
        s1_err_reg   <= accept && !hit;
        s1_data_reg  <= (accept && hit) ? mem[idx[gi]] : '0;
        s1_user_reg  <= accept ? req_user[gi] : '0;
      end
    end

    if (READ_LATENCY == 2) begin : g_lat2
      logic                  s2_valid_reg;
      logic                  s2_err_reg;
      logic [DATA_WIDTH-1:0] s2_data_reg;
      logic [USER_WIDTH-1:0] s2_user_reg;

      always_ff @(posedge mem_clk) begin
        if (!cpu_reset) begin
          s2_valid_reg <= 1'b0;
          s2_err_reg   <= 1'b0;
          s2_data_reg  <= '0;
          s2_user_reg  <= '0;
        end else begin
          s2_valid_reg <= s1_valid_reg;
          s2_err_reg   <= s1_err_reg;
          s2_data_reg  <= s1_data_reg;
          s2_user_reg  <= s1_user_reg;
        end
      end

      assign rsp_valid[gi] = s2_valid_reg;
      assign rsp_err[gi]   = s2_err_reg;
      assign rsp_data[gi]  = s2_data_reg;
      assign rsp_user[gi]  = s2_user_reg;
    end else begin : g_lat1
      assign rsp_valid[gi] = s1_valid_reg;
      assign rsp_err[gi]   = s1_err_reg;
      assign rsp_data[gi]  = s1_data_reg;
      assign rsp_user[gi]  = s1_user_reg;
    end
  end

  // Port A's lane update is scheduled last so it wins a same-word, same-lane collision.
  always_ff @(posedge mem_clk) begin
    for (int k = 0; k < NB; k++) begin
      if (wr_en[1] && be[1][k]) mem[idx[1]][k*8 +: 8] <= wdata[1][k*8 +: 8];
      if (wr_en[0] && be[0][k]) mem[idx[0]][k*8 +: 8] <= wdata[0][k*8 +: 8];
    end
  end

endmodule
